// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: enable and timing outputs of the VGA timing generator
interface vga_timing_gen_if #(parameter int CW = 10);
  logic          enable;
  logic [CW-1:0] xcoord;
  logic [CW-1:0] ycoord;
  logic          hsync;
  logic          vsync;
  logic          nocolor;
  logic          pixel_tick;
  logic          line_start;
  logic          frame_start;
  modport master (
    input  enable,
    output xcoord, ycoord, hsync, vsync, nocolor, pixel_tick, line_start, frame_start
  );
  modport slave (
    output enable,
    input  xcoord, ycoord, hsync, vsync, nocolor, pixel_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider with horizontal/vertical counters and registered sync decode
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input logic              clock,
  input logic              reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] divcnt, div_nxt;
  logic [CW-1:0] hcount, vcount, h_nxt, v_nxt;
  logic          tick, h_wrap, v_wrap, active, hs_on, vs_on;
  // next counter values; outputs are decoded from these so they line up with the counters
  always_comb begin
    tick    = vga.enable && divcnt == DW'(CLK_DIV - 1);
    h_wrap  = hcount == CW'(H_TOTAL - 1);
    v_wrap  = vcount == CW'(V_TOTAL - 1);
    div_nxt = tick ? '0 : divcnt + 1'b1;
    h_nxt   = tick ? (h_wrap ? '0 : hcount + 1'b1) : hcount;
    v_nxt   = tick && h_wrap ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
    active  = h_nxt < CW'(H_ACTIVE) && v_nxt < CW'(V_ACTIVE);
    hs_on   = h_nxt >= CW'(H_ACTIVE + H_FP) && h_nxt < CW'(H_ACTIVE + H_FP + H_SYNC);
    vs_on   = v_nxt >= CW'(V_ACTIVE + V_FP) && v_nxt < CW'(V_ACTIVE + V_FP + V_SYNC);
  end
  // counters and registered outputs; everything holds while enable is low
  always_ff @(posedge clock) begin
    if (reset) begin
      divcnt          <= '0;
      hcount          <= '0;
      vcount          <= '0;
      vga.xcoord      <= '0;
      vga.ycoord      <= '0;
      vga.nocolor     <= 1'b0;
      vga.hsync       <= ~HS_POL;
      vga.vsync       <= ~VS_POL;
      vga.pixel_tick  <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else if (vga.enable) begin
      divcnt          <= div_nxt;
      hcount          <= h_nxt;
      vcount          <= v_nxt;
      vga.xcoord      <= active ? h_nxt : '0;
      vga.ycoord      <= active ? v_nxt : '0;
      vga.nocolor     <= ~active;
      vga.hsync       <= hs_on ? HS_POL : ~HS_POL;
      vga.vsync       <= vs_on ? VS_POL : ~VS_POL;
      vga.pixel_tick  <= tick;
      vga.line_start  <= tick && h_wrap;
      vga.frame_start <= tick && h_wrap && v_wrap;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for the VGA timing generator
module tb_vga_timing_gen;
  localparam int DIV = 2, HA = 8, HF = 2, HSW = 3, HB = 2, VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic hs, vs, nc, pt, ls, fs;
  } obs_t;
  logic clock, reset, enable;
  int n_checks = 0, n_fail = 0;
  int md, mh, mv;
  obs_t mo, got, exp_o, snap;
  obs_t q[$];
  vga_timing_gen_if #(.CW(4)) vif ();
  vga_timing_gen_if #(.CW(3)) fif ();
  assign vif.enable = enable;
  assign fif.enable = enable;
  vga_timing_gen #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
  ) dut (.clock(clock), .reset(reset), .vga(vif.master));
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(3)
  ) dut_fast (.clock(clock), .reset(reset), .vga(fif.master));
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  function automatic obs_t cur();
    return '{vif.xcoord, vif.ycoord, vif.hsync, vif.vsync, vif.nocolor,
             vif.pixel_tick, vif.line_start, vif.frame_start};
  endfunction
  task automatic drive(input logic r, input logic e);
    logic t, lw, fw, act;
    reset = r;
    enable = e;
    if (r) begin
      md = 0; mh = 0; mv = 0;
      mo = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end else if (e) begin
      t  = md == DIV - 1;
      md = t ? 0 : md + 1;
      lw = t && mh == HT - 1;
      fw = lw && mv == VT - 1;
      if (t) mh = lw ? 0 : mh + 1;
      if (lw) mv = fw ? 0 : mv + 1;
      act   = mh < HA && mv < VA;
      mo.x  = act ? 4'(mh) : 4'd0;
      mo.y  = act ? 4'(mv) : 4'd0;
      mo.nc = ~act;
      mo.hs = !(mh >= HA + HF && mh < HA + HF + HSW);
      mo.vs = !(mv >= VA + VF && mv < VA + VF + VSW);
      mo.pt = t;
      mo.ls = lw;
      mo.fs = fw;
    end
    q.push_back(mo);
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    drive(1, 1);
    exp_o = q.pop_front();
    got = cur();
    n_checks++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", got, exp_o);
    end
    n_checks++;
    if (got !== obs_t'({4'd0, 4'd0, 6'b110000})) begin
      n_fail++;
      $display("FAIL reset_const: got %h expected %h", got, {4'd0, 4'd0, 6'b110000});
    end
  endtask
  task automatic test_first_tick();
    for (int i = 1; i <= 2; i++) begin
      drive(0, 1);
      exp_o = q.pop_front();
      got = cur();
      n_checks++;
      if (got !== exp_o || got.pt !== (i == DIV)) begin
        n_fail++;
        $display("FAIL first_tick[%0d]: got %h expected %h pt %0d", i, got, exp_o, i == DIV);
      end
    end
  endtask
  task automatic test_line();
    int ls_cnt = 0;
    logic prev_pt = 1'b0;
    for (int i = 0; i < 2 * HT * DIV; i++) begin
      drive(0, 1);
      exp_o = q.pop_front();
      got = cur();
      ls_cnt += int'(got.ls);
      n_checks++;
      if (got !== exp_o || (prev_pt && got.pt)) begin
        n_fail++;
        $display("FAIL line[%0d]: got %h expected %h", i, got, exp_o);
      end
      prev_pt = got.pt;
    end
    n_checks++;
    if (ls_cnt != 2) begin
      n_fail++;
      $display("FAIL line_start_count: got %0d expected 2", ls_cnt);
    end
  endtask
  task automatic test_frame();
    int first = -1, period = -1;
    for (int i = 0; i < 2 * HT * VT * DIV + 4 && period < 0; i++) begin
      drive(0, 1);
      exp_o = q.pop_front();
      got = cur();
      n_checks++;
      if (got !== exp_o || (got.fs && !got.ls)) begin
        n_fail++;
        $display("FAIL frame[%0d]: got %h expected %h", i, got, exp_o);
      end
      if (got.fs) begin
        if (first >= 0) period = i - first;
        else first = i;
      end
    end
    n_checks++;
    if (period != HT * VT * DIV) begin
      n_fail++;
      $display("FAIL frame_period: got %0d expected %0d", period, HT * VT * DIV);
    end
  endtask
  task automatic test_enable_hold();
    int guard = 0;
    while (!(mh == 3 && md == 0) && guard < 200) begin
      drive(0, 1);
      void'(q.pop_front());
      guard++;
    end
    snap = cur();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0);
      exp_o = q.pop_front();
      got = cur();
      n_checks++;
      if (got !== exp_o || got !== snap) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h expected %h", i, got, exp_o);
      end
    end
    for (int i = 0; i < 2 * HT * DIV; i++) begin
      drive(0, 1);
      exp_o = q.pop_front();
      got = cur();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL resume[%0d]: got %h expected %h", i, got, exp_o);
      end
    end
  endtask
  task automatic test_reset_mid();
    int guard = 0;
    while (!(mh == 5 && mv == 2) && guard < 2 * HT * VT * DIV) begin
      drive(0, 1);
      void'(q.pop_front());
      guard++;
    end
    n_checks++;
    if (!(mh == 5 && mv == 2)) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got h%0d v%0d expected h5 v2", mh, mv);
    end
    drive(1, 1);
    exp_o = q.pop_front();
    got = cur();
    n_checks++;
    if (got !== exp_o || got.fs !== 1'b0 || got.hs !== 1'b1 || got.nc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", got, exp_o);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
      exp_o = q.pop_front();
      got = cur();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp_o);
      end
    end
  endtask
  task automatic test_fast();
    int h, v;
    logic hs_e, fs_e;
    logic [2:0] x_e;
    drive(1, 1);
    void'(q.pop_front());
    for (int k = 1; k <= 100; k++) begin
      drive(0, 1);
      void'(q.pop_front());
      h    = k % 8;
      v    = (k / 8) % 6;
      hs_e = h == 5 || h == 6;
      fs_e = k % 48 == 0;
      x_e  = (h < 4 && v < 3) ? 3'(h) : 3'd0;
      n_checks++;
      if (fif.hsync !== hs_e || fif.frame_start !== fs_e || fif.pixel_tick !== 1'b1 || fif.xcoord !== x_e) begin
        n_fail++;
        $display("FAIL fast[%0d]: got hs%b fs%b pt%b x%0d expected hs%b fs%b pt1 x%0d",
                 k, fif.hsync, fif.frame_start, fif.pixel_tick, fif.xcoord, hs_e, fs_e, x_e);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    md = 0; mh = 0; mv = 0;
    mo = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_first_tick();
    test_line();
    test_frame();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
